// File: rtl/tdm_pkg.sv
// Shared TDM link definitions: slot indices for the mux/demux pair and
// the receive-side framing state encoding.
package tdm_pkg;

    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

endpackage : tdm_pkg

// File: rtl/demux1to4_tdm.sv
// 1:4 TDM demultiplexer: collects slots a..d into shadow registers and
// publishes a complete frame atomically on the slot-d beat.
module demux1to4_tdm
    import tdm_pkg::*;
#(
    parameter int unsigned DATA_W = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    input  logic              i_sync,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_b,
    output logic [DATA_W-1:0] o_c,
    output logic [DATA_W-1:0] o_d,
    output logic              o_frame_vld,
    output logic              o_lock,
    output logic [1:0]        o_slot,
    output logic              o_sync_err
);

    state_e            state_q, state_d;
    logic [1:0]        slot_q, slot_d;
    logic [DATA_W-1:0] sh0_q, sh0_d;
    logic [DATA_W-1:0] sh1_q, sh1_d;
    logic [DATA_W-1:0] sh2_q, sh2_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] c_q, c_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic              frame_vld_q, frame_vld_d;
    logic              sync_err_q, sync_err_d;

    // Next-state, slot tracking, shadow capture and frame publication
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        sh0_d       = sh0_q;
        sh1_d       = sh1_q;
        sh2_d       = sh2_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        d_d         = d_q;
        frame_vld_d = 1'b0;
        sync_err_d  = 1'b0;

        if (i_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (i_sync) begin
                        sh0_d   = i_data;
                        slot_d  = SLOT_B;
                        state_d = ST_LOCK;
                    end
                end
                default: begin
                    if (i_sync && (slot_q != SLOT_A)) begin
                        // Early sync: drop the partial frame, restart at slot a
                        sync_err_d = 1'b1;
                        sh0_d      = i_data;
                        slot_d     = SLOT_B;
                    end else if (!i_sync && (slot_q == SLOT_A)) begin
                        sync_err_d = 1'b1;
                        slot_d     = SLOT_A;
                        state_d    = ST_HUNT;
                    end else begin
                        case (slot_q)
                            SLOT_B: begin
                                sh1_d  = i_data;
                                slot_d = SLOT_C;
                            end
                            SLOT_C: begin
                                sh2_d  = i_data;
                                slot_d = SLOT_D;
                            end
                            SLOT_D: begin
                                a_d         = sh0_q;
                                b_d         = sh1_q;
                                c_d         = sh2_q;
                                d_d         = i_data;
                                frame_vld_d = 1'b1;
                                slot_d      = SLOT_A;
                            end
                            default: begin
                                sh0_d  = i_data;
                                slot_d = SLOT_B;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_HUNT;
            slot_q      <= SLOT_A;
            sh0_q       <= '0;
            sh1_q       <= '0;
            sh2_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            frame_vld_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            sh0_q       <= sh0_d;
            sh1_q       <= sh1_d;
            sh2_q       <= sh2_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            frame_vld_q <= frame_vld_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign o_a         = a_q;
    assign o_b         = b_q;
    assign o_c         = c_q;
    assign o_d         = d_q;
    assign o_frame_vld = frame_vld_q;
    assign o_lock      = (state_q == ST_LOCK);
    assign o_slot      = slot_q;
    assign o_sync_err  = sync_err_q;

endmodule : demux1to4_tdm

// File: tb/tb_demux1to4_tdm.sv
// Directed plus randomized bench for demux1to4_tdm against a frame-level
// reference model.
module tb_demux1to4_tdm;

    localparam int unsigned DATA_W = 4;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              sync;
    logic [DATA_W-1:0] o_a, o_b, o_c, o_d;
    logic              o_frame_vld, o_lock, o_sync_err;
    logic [1:0]        o_slot;

    demux1to4_tdm #(.DATA_W(DATA_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_data      (data),
        .i_valid     (valid),
        .i_sync      (sync),
        .o_a         (o_a),
        .o_b         (o_b),
        .o_c         (o_c),
        .o_d         (o_d),
        .o_frame_vld (o_frame_vld),
        .o_lock      (o_lock),
        .o_slot      (o_slot),
        .o_sync_err  (o_sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int n_pulses;

    // Reference model: a frame buffer filled by slot index, published whole
    bit              m_lock;
    int              m_slot;
    logic [3:0]      m_buf [4];
    logic [3:0]      m_out [4];
    bit              m_fv;
    bit              m_err;

    task automatic model_reset();
        m_lock = 0;
        m_slot = 0;
        m_fv   = 0;
        m_err  = 0;
        for (int i = 0; i < 4; i++) begin
            m_buf[i] = '0;
            m_out[i] = '0;
        end
    endtask

    task automatic model_beat(input bit v, input bit s, input logic [3:0] d);
        m_fv  = 0;
        m_err = 0;
        if (!v) return;
        if (!m_lock) begin
            if (s) begin
                m_buf[0] = d;
                m_slot   = 1;
                m_lock   = 1;
            end
        end else if (s) begin
            if (m_slot != 0) m_err = 1;
            m_buf[0] = d;
            m_slot   = 1;
        end else if (m_slot == 0) begin
            m_err  = 1;
            m_lock = 0;
        end else begin
            m_buf[m_slot] = d;
            if (m_slot == 3) begin
                m_out  = m_buf;
                m_fv   = 1;
                m_slot = 0;
            end else begin
                m_slot = m_slot + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".a"},    32'(o_a),         32'(m_out[0]));
        chk({tag, ".b"},    32'(o_b),         32'(m_out[1]));
        chk({tag, ".c"},    32'(o_c),         32'(m_out[2]));
        chk({tag, ".d"},    32'(o_d),         32'(m_out[3]));
        chk({tag, ".fv"},   32'(o_frame_vld), 32'(m_fv));
        chk({tag, ".lock"}, 32'(o_lock),      32'(m_lock));
        chk({tag, ".slot"}, 32'(o_slot),      32'(m_slot));
        chk({tag, ".err"},  32'(o_sync_err),  32'(m_err));
    endtask

    // One clock: drive, wait for the edge, update the model, compare
    task automatic step(input string tag, input bit v, input bit s, input logic [3:0] d);
        valid = v;
        sync  = s;
        data  = d;
        @(posedge clk);
        #1;
        model_beat(v, s, d);
        if (o_frame_vld) n_pulses++;
        check_all(tag);
    endtask

    task automatic frame(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        step(tag, 1, 1, a);
        step(tag, 1, 0, b);
        step(tag, 1, 0, c);
        step(tag, 1, 0, d);
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        sync  = 1'b0;
        data  = '0;
        n_pulses = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // 1: basic frame
        frame("basic", 4'h1, 4'h0, 4'h1, 4'h1);
        step("basic_after", 0, 0, 4'h0);

        // 2: 16 frames with random idle gaps
        n_pulses = 0;
        for (int f = 0; f < 16; f++) begin
            for (int s = 0; s < 4; s++) begin
                int gaps;
                gaps = int'($urandom_range(0, 2));
                for (int g = 0; g < gaps; g++)
                    step("gap", 0, 1'($urandom), 4'($urandom));
                step("b2b", 1, (s == 0), 4'(f) + 4'(s));
            end
        end
        chk("b2b_pulse_count", 32'(n_pulses), 32'd16);

        // 3: early sync aborts a partial frame
        frame("f5678", 4'h5, 4'h6, 4'h7, 4'h8);
        step("abort_a", 1, 1, 4'h1);
        step("abort_b", 1, 0, 4'h2);
        step("early_sync", 1, 1, 4'h9);
        step("abort_bb", 1, 0, 4'hA);
        step("abort_cc", 1, 0, 4'hB);
        step("abort_dd", 1, 0, 4'hC);

        // 4: missing sync drops lock, stray beats ignored, relock
        step("miss_sync", 1, 0, 4'h3);
        for (int i = 0; i < 6; i++) step("stray", 1, 0, 4'($urandom));
        frame("relock", 4'hD, 4'hE, 4'hF, 4'h0);

        // 5: asynchronous reset mid-frame
        step("pre_rst_a", 1, 1, 4'h7);
        step("pre_rst_b", 1, 0, 4'h7);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        rst = 1'b0;
        frame("post_rst", 4'h4, 4'h3, 4'h2, 4'h1);

        // 6: sync without valid in HUNT and LOCK
        step("miss2", 1, 0, 4'h0);
        step("nv_hunt", 0, 1, 4'hF);
        step("lock_a", 1, 1, 4'h8);
        step("nv_lock", 0, 1, 4'h9);
        step("lock_b", 1, 0, 4'hA);
        step("lock_c", 1, 0, 4'hB);
        step("lock_d", 1, 0, 4'hC);

        // Random soak
        for (int i = 0; i < 400; i++) begin
            bit v, s;
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 4) == 0);
            step("rand", v, s, 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_demux1to4_tdm
